// File: rtl/char_motion_unit.sv
// rtl/char_motion_unit.sv - per-character heading/position engine on a shared step tick
module char_motion_unit #(
  parameter int NUM_CHARS  = 2,
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 24,
  parameter int X_W        = 5,
  parameter int Y_W        = 5,
  parameter int TICK_DIV   = 1000000,
  parameter int NO_REVERSE = 1,
  parameter int WRAP       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CHARS-1:0]       req_valid,
  input  logic [NUM_CHARS-1:0]       req_dir,
  input  logic [NUM_CHARS-1:0]       req_axis,
  input  logic [NUM_CHARS-1:0]       load_en,
  input  logic [X_W-1:0]             load_x,
  input  logic [Y_W-1:0]             load_y,
  output logic [2*NUM_CHARS-1:0]     char_dir,
  output logic [X_W*NUM_CHARS-1:0]   pos_x,
  output logic [Y_W*NUM_CHARS-1:0]   pos_y,
  output logic [NUM_CHARS-1:0]       moving,
  output logic                       step_pulse,
  output logic [NUM_CHARS-1:0]       req_reject
);

  localparam int              CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [X_W-1:0]   X_MAX   = X_W'(GRID_W - 1);
  localparam logic [X_W-1:0]   X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [Y_W-1:0]   Y_ONE   = Y_W'(1);

  // Heading codes: bit 1 set = negative direction, bit 0 = axis.
  localparam logic [1:0] HEAD_PX = 2'd0;
  localparam logic [1:0] HEAD_PY = 2'd1;
  localparam logic [1:0] HEAD_NX = 2'd2;
  localparam logic [1:0] HEAD_NY = 2'd3;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 step_q, step_d;
  logic [1:0]           dir_q [NUM_CHARS];
  logic [1:0]           dir_d [NUM_CHARS];
  logic [X_W-1:0]       x_q   [NUM_CHARS];
  logic [X_W-1:0]       x_d   [NUM_CHARS];
  logic [Y_W-1:0]       y_q   [NUM_CHARS];
  logic [Y_W-1:0]       y_d   [NUM_CHARS];
  logic [NUM_CHARS-1:0] moving_q, moving_d;
  logic [NUM_CHARS-1:0] rej_q, rej_d;
  logic [1:0]           req_code [NUM_CHARS];
  logic [X_W-1:0]       load_x_c;
  logic [Y_W-1:0]       load_y_c;

  // Shared step timer; step_d marks the edge on which every moving channel advances.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Clamp the shared load bus into the grid.
  always_comb begin
    load_x_c = (load_x > X_MAX) ? X_MAX : load_x;
    load_y_c = (load_y > Y_MAX) ? Y_MAX : load_y;
  end

  // Translate each (dir, axis) request into a heading code.
  always_comb begin
    for (int i = 0; i < NUM_CHARS; i++) begin
      req_code[i] = {~req_dir[i], req_axis[i]};
    end
  end

  // Per-channel next state: load overrides; otherwise move on old heading, then steer.
  always_comb begin
    for (int i = 0; i < NUM_CHARS; i++) begin
      dir_d[i]    = dir_q[i];
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      moving_d[i] = moving_q[i];
      rej_d[i]    = 1'b0;
      if (load_en[i]) begin
        x_d[i]      = load_x_c;
        y_d[i]      = load_y_c;
        moving_d[i] = 1'b0;
      end else begin
        if (step_d && moving_q[i]) begin
          case (dir_q[i])
            HEAD_PX: x_d[i] = (x_q[i] == X_MAX) ? ((WRAP != 0) ? '0 : X_MAX) : x_q[i] + X_ONE;
            HEAD_NX: x_d[i] = (x_q[i] == '0) ? ((WRAP != 0) ? X_MAX : '0) : x_q[i] - X_ONE;
            HEAD_PY: y_d[i] = (y_q[i] == Y_MAX) ? ((WRAP != 0) ? '0 : Y_MAX) : y_q[i] + Y_ONE;
            HEAD_NY: y_d[i] = (y_q[i] == '0) ? ((WRAP != 0) ? Y_MAX : '0) : y_q[i] - Y_ONE;
            default: ;
          endcase
        end
        if (req_valid[i]) begin
          if ((NO_REVERSE != 0) && moving_q[i] && (req_code[i] == (dir_q[i] ^ 2'd2))) begin
            rej_d[i] = 1'b1;
          end else begin
            dir_d[i]    = req_code[i];
            moving_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      step_q   <= 1'b0;
      moving_q <= '0;
      rej_q    <= '0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        dir_q[i] <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      moving_q <= moving_d;
      rej_q    <= rej_d;
      for (int i = 0; i < NUM_CHARS; i++) begin
        dir_q[i] <= dir_d[i];
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
      end
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    char_dir = '0;
    pos_x    = '0;
    pos_y    = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      char_dir[2*i +: 2]   = dir_q[i];
      pos_x[X_W*i +: X_W]  = x_q[i];
      pos_y[Y_W*i +: Y_W]  = y_q[i];
    end
  end

  assign moving     = moving_q;
  assign step_pulse = step_q;
  assign req_reject = rej_q;

endmodule

// File: tb/tb_char_motion_unit.sv
// tb/tb_char_motion_unit.sv - scoreboard bench for char_motion_unit (wrap/no-reverse and clamp/reverse builds)
module tb_char_motion_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] req_valid, req_dir, req_axis, load_en;
  logic [2:0] load_x, load_y;

  logic [3:0] dir_a, dir_b;
  logic [5:0] px_a, py_a, px_b, py_b;
  logic [1:0] mv_a, mv_b, rej_a, rej_b;
  logic       step_a, step_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       step;
    logic [1:0] rej_a;
    logic [1:0] rej_b;
    logic [3:0] dir_a;
    logic [3:0] dir_b;
    logic [5:0] x_a;
    logic [5:0] y_a;
    logic [5:0] x_b;
    logic [5:0] y_b;
    logic [1:0] mv;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  exp_t  mon_e;
  string mon_n;

  always #5 clk = ~clk;

  char_motion_unit #(
    .NUM_CHARS(2), .GRID_W(8), .GRID_H(6), .X_W(3), .Y_W(3),
    .TICK_DIV(4), .NO_REVERSE(1), .WRAP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_dir(req_dir), .req_axis(req_axis),
    .load_en(load_en), .load_x(load_x), .load_y(load_y),
    .char_dir(dir_a), .pos_x(px_a), .pos_y(py_a), .moving(mv_a),
    .step_pulse(step_a), .req_reject(rej_a)
  );

  char_motion_unit #(
    .NUM_CHARS(2), .GRID_W(8), .GRID_H(6), .X_W(3), .Y_W(3),
    .TICK_DIV(4), .NO_REVERSE(0), .WRAP(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_dir(req_dir), .req_axis(req_axis),
    .load_en(load_en), .load_x(load_x), .load_y(load_y),
    .char_dir(dir_b), .pos_x(px_b), .pos_y(py_b), .moving(mv_b),
    .step_pulse(step_b), .req_reject(rej_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input string n, input logic st, input logic [1:0] ra, input logic [1:0] rb,
                      input logic [3:0] da, input logic [3:0] db, input logic [5:0] xa,
                      input logic [5:0] ya, input logic [5:0] xb, input logic [5:0] yb,
                      input logic [1:0] mv);
    exp_t e;
    e.step = st; e.rej_a = ra; e.rej_b = rb; e.dir_a = da; e.dir_b = db;
    e.x_a = xa; e.y_a = ya; e.x_b = xb; e.y_b = yb; e.mv = mv;
    sb.push_back(e);
    sb_name.push_back(n);
  endtask

  // Monitor: every step pulse or reject strobe consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && (step_a || step_b || rej_a != 2'b00 || rej_b != 2'b00)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: step_a=%0b step_b=%0b rej_a=%b rej_b=%b, required none", step_a, step_b, rej_a, rej_b);
      end else begin
        mon_e = sb.pop_front();
        mon_n = sb_name.pop_front();
        chk({mon_n, ".step_a"}, int'(step_a), int'(mon_e.step));
        chk({mon_n, ".step_b"}, int'(step_b), int'(mon_e.step));
        chk({mon_n, ".rej_a"},  int'(rej_a),  int'(mon_e.rej_a));
        chk({mon_n, ".rej_b"},  int'(rej_b),  int'(mon_e.rej_b));
        chk({mon_n, ".dir_a"},  int'(dir_a),  int'(mon_e.dir_a));
        chk({mon_n, ".dir_b"},  int'(dir_b),  int'(mon_e.dir_b));
        chk({mon_n, ".x_a"},    int'(px_a),   int'(mon_e.x_a));
        chk({mon_n, ".y_a"},    int'(py_a),   int'(mon_e.y_a));
        chk({mon_n, ".x_b"},    int'(px_b),   int'(mon_e.x_b));
        chk({mon_n, ".y_b"},    int'(py_b),   int'(mon_e.y_b));
        chk({mon_n, ".mv_a"},   int'(mv_a),   int'(mon_e.mv));
        chk({mon_n, ".mv_b"},   int'(mv_b),   int'(mon_e.mv));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_steps(input int n);
    enable = 1'b1;
    repeat (4 * n) tick();
    enable = 1'b0;
  endtask

  task automatic request(input logic [1:0] v, input logic [1:0] d, input logic [1:0] a);
    req_valid = v; req_dir = d; req_axis = a;
    tick();
    req_valid = 2'b00;
  endtask

  task automatic load(input logic [1:0] le, input logic [2:0] lx, input logic [2:0] ly);
    load_en = le; load_x = lx; load_y = ly;
    tick();
    load_en = 2'b00;
  endtask

  // Request and/or load presented on the fourth enabled edge, i.e. the step edge.
  task automatic step_with(input logic [1:0] v, input logic [1:0] d, input logic [1:0] a,
                           input logic [1:0] le, input logic [2:0] lx, input logic [2:0] ly);
    enable = 1'b1;
    repeat (3) tick();
    req_valid = v; req_dir = d; req_axis = a;
    load_en = le; load_x = lx; load_y = ly;
    tick();
    req_valid = 2'b00;
    load_en   = 2'b00;
    enable    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".dir_a"},  int'(dir_a),  0);
    chk({tag, ".x_a"},    int'(px_a),   0);
    chk({tag, ".y_a"},    int'(py_a),   0);
    chk({tag, ".mv_a"},   int'(mv_a),   0);
    chk({tag, ".step_a"}, int'(step_a), 0);
    chk({tag, ".rej_a"},  int'(rej_a),  0);
    chk({tag, ".dir_b"},  int'(dir_b),  0);
    chk({tag, ".x_b"},    int'(px_b),   0);
    chk({tag, ".mv_b"},   int'(mv_b),   0);
    chk({tag, ".step_b"}, int'(step_b), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    req_valid = '0; req_dir = '0; req_axis = '0;
    load_en = '0; load_x = '0; load_y = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Idle stepping: pulses, nobody moves.
    push("idle_s1", 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    push("idle_s2", 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    do_steps(2);
    tick();

    // enable low freezes the counter mid-count.
    push("freeze_step", 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    enable = 1'b1; repeat (2) tick();
    enable = 1'b0; repeat (5) tick();
    enable = 1'b1; repeat (2) tick();
    enable = 1'b0; tick();

    // Ch0 heads +y and walks three cells; ch1 untouched.
    request(2'b01, 2'b01, 2'b01);
    push("up_s1", 1'b1, 2'b00, 2'b00, 4'd1, 4'd1, 6'd0, 6'd1, 6'd0, 6'd1, 2'b01);
    push("up_s2", 1'b1, 2'b00, 2'b00, 4'd1, 4'd1, 6'd0, 6'd2, 6'd0, 6'd2, 2'b01);
    push("up_s3", 1'b1, 2'b00, 2'b00, 4'd1, 4'd1, 6'd0, 6'd3, 6'd0, 6'd3, 2'b01);
    do_steps(3);
    tick();

    // Ch0 at x=7 heading +x: wrap build goes to 0, clamp build holds 7.
    load(2'b01, 3'd7, 3'd3);
    request(2'b01, 2'b01, 2'b00);
    push("wrap_x", 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 6'd0, 6'd3, 6'd7, 6'd3, 2'b01);
    do_steps(1);
    tick();

    // Ch1 heading -x then asks for +x: rejected only in the no-reverse build.
    request(2'b10, 2'b00, 2'b00);
    push("reverse", 1'b0, 2'b10, 2'b00, 4'b1000, 4'b0000, 6'd0, 6'd3, 6'd7, 6'd3, 2'b11);
    request(2'b10, 2'b10, 2'b00);
    tick();

    // Both to (3,3); ch0 heading +x turns to -y exactly on a step edge.
    load(2'b11, 3'd3, 3'd3);
    request(2'b01, 2'b01, 2'b00);
    push("turn_on_step", 1'b1, 2'b00, 2'b00, 4'd11, 4'd3, 6'd28, 6'd27, 6'd28, 6'd27, 2'b01);
    step_with(2'b01, 2'b00, 2'b01, 2'b00, 3'd0, 3'd0);
    tick();
    push("turn_next", 1'b1, 2'b00, 2'b00, 4'd11, 4'd3, 6'd28, 6'd26, 6'd28, 6'd26, 2'b01);
    push("down_y1",   1'b1, 2'b00, 2'b00, 4'd11, 4'd3, 6'd28, 6'd25, 6'd28, 6'd25, 2'b01);
    push("down_y0",   1'b1, 2'b00, 2'b00, 4'd11, 4'd3, 6'd28, 6'd24, 6'd28, 6'd24, 2'b01);
    push("wrap_y",    1'b1, 2'b00, 2'b00, 4'd11, 4'd3, 6'd28, 6'd29, 6'd28, 6'd24, 2'b01);
    do_steps(4);
    tick();

    // Load with y clamped, coincident with a step and a reversing request.
    push("load_beats", 1'b1, 2'b00, 2'b00, 4'd11, 4'd3, 6'd29, 6'd29, 6'd29, 6'd29, 2'b00);
    step_with(2'b01, 2'b01, 2'b01, 2'b01, 3'd5, 3'd7);
    tick();

    // Reset in mid-count discards the count and channel state.
    enable = 1'b1;
    request(2'b01, 2'b01, 2'b00);
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_reset_no_pulse", int'(step_a), 0);
    end
    push("post_reset_step", 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00);
    tick();
    enable = 1'b0;
    repeat (4) tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
